// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if
//   Parallel output port of the serial-in/parallel-out frame controller.
//   Carries one assembled word with a valid/ready handshake.
//
//   Signals:
//     out_data  [WIDTH] received word, first serial bit in the MSB
//     out_valid          out_data holds an unconsumed word
//     out_ready          sink accepts the word when high together with out_valid
//
//   Modports:
//     master  word source (the frame controller)
//     slave   word sink
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
//   Sequencing controller for a serial-in/parallel-out shift datapath.
//   It waits for a start bit (data_in low on a bit strobe) and shifts in
//   WIDTH data bits MSB-first. It then checks the stop bit and hands the
//   assembled word to a valid/ready output port. shift_en is exported so an
//   external shift register can run in lockstep with the internal one.
//
//   Optional feature: define SIPO_FRAME_CTRL_PARITY_EN to add an even-parity
//   bit between the data bits and the stop bit, plus a sticky parity_err
//   output.
//
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous reset, active-high
//     bit_stb    in   one-cycle strobe at the sample point of each serial bit
//     data_in    in   serial line, idles high
//     shift_en   out  combinational, high on cycles that shift in a data bit
//     clear_err  in   clears the sticky error flags
//     frame_err  out  sticky, stop bit sampled low
//     overrun    out  sticky, good frame dropped because a word was still held
//     parity_err out  sticky, parity mismatch (only with SIPO_FRAME_CTRL_PARITY_EN)
//     busy       out  controller is inside a frame
//     out_port   master side of sipo_frame_ctrl_if (out_data/out_valid/out_ready)
//
//   State   | meaning
//   --------+----------------------------------------------------
//   S_IDLE  | line idle, waiting for a start bit on a strobe
//   S_DATA  | shifting in WIDTH data bits, one per strobe
//   S_PARITY| sampling the parity bit (parity build only)
//   S_STOP  | sampling the stop bit, delivering or dropping the word
module sipo_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_stb,
  input  logic data_in,
  output logic shift_en,
  input  logic clear_err,
  output logic frame_err,
  output logic overrun,
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  output logic parity_err,
`endif
  output logic busy,
  sipo_frame_ctrl_if.master out_port
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_STOP   = 2'd2
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    , S_PARITY = 2'd3
`endif
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;

  logic             shift;
  logic             stop_ok;
  logic             stop_bad;
  logic             word_ok;
  logic             load;
  logic             ovr_set;

`ifdef SIPO_FRAME_CTRL_PARITY_EN
  // Running XOR of data bits and parity bit; 1 at the stop strobe means the
  // frame failed even parity.
  logic par_q;
  logic par_d;
  logic perr_q;
  logic perr_set;
`endif

  // Next-state logic; every transition is qualified by bit_stb.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift    = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    par_d    = par_q;
`endif
    if (bit_stb) begin
      case (state_q)
        S_IDLE: begin
          if (!data_in) begin
            state_d = S_DATA;
            cnt_d   = '0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end
        S_DATA: begin
          shift = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SIPO_FRAME_CTRL_PARITY_EN
          par_d = par_q ^ data_in;
          if (cnt_q == CNT_LAST) state_d = S_PARITY;
`else
          if (cnt_q == CNT_LAST) state_d = S_STOP;
`endif
        end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        S_PARITY: begin
          par_d   = par_q ^ data_in;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
          if (data_in) stop_ok  = 1'b1;
          else         stop_bad = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef SIPO_FRAME_CTRL_PARITY_EN
  // A bad stop bit masks any parity result: only frame_err is raised then.
  assign word_ok  = stop_ok && !par_q;
  assign perr_set = stop_ok && par_q;
`else
  assign word_ok  = stop_ok;
`endif

  // Consuming the held word on the same cycle frees the slot for the new one.
  assign load    = word_ok && (!valid_q || out_port.out_ready);
  assign ovr_set = word_ok && valid_q && !out_port.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (shift) shreg_q <= {shreg_q[WIDTH-2:0], data_in};

      if (load) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && out_port.out_ready) begin
        valid_q <= 1'b0;
      end

      // Setting wins over clear_err so an error in the clearing cycle is kept.
      if (stop_bad)       ferr_q <= 1'b1;
      else if (clear_err) ferr_q <= 1'b0;

      if (ovr_set)        ovr_q <= 1'b1;
      else if (clear_err) ovr_q <= 1'b0;
    end
  end

`ifdef SIPO_FRAME_CTRL_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q <= par_d;
      if (perr_set)       perr_q <= 1'b1;
      else if (clear_err) perr_q <= 1'b0;
    end
  end

  assign parity_err = perr_q;
`endif

  assign shift_en           = shift && !reset;
  assign busy               = (state_q != S_IDLE) && !reset;
  assign frame_err          = ferr_q;
  assign overrun            = ovr_q;
  assign out_port.out_data  = data_q;
  assign out_port.out_valid = valid_q;

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Sequencing controller for a serial-in/parallel-out shift datapath. It detects a start bit on a serial line and counts WIDTH data bits, qualifying each with a bit strobe. It checks the stop bit, then presents the assembled word on a valid/ready output port. It drives an internal MSB-first left-shift register and also exports the shift enable, so an external shift register can run in lockstep.

Parameters:
WIDTH, 8, data bits per frame (2..32)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
bit_stb  in  1  one-cycle strobe marking the sample point of each serial bit
data_in  in  1  serial line; idles high
shift_en  out  1  combinational; high on cycles where a data bit is shifted in
out_data  out  WIDTH  received word; first received bit lands in the MSB
out_valid  out  1  out_data holds an unconsumed word
out_ready  in  1  downstream accepts the word when high together with out_valid
frame_err  out  1  sticky; stop bit sampled as 0
overrun  out  1  sticky; a completed frame was dropped because out_valid was still held
clear_err  in  1  clears frame_err, overrun (and parity_err if present)
busy  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled only on posedge clk.
- Reset values: state=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, frame_err=0, overrun=0. shift_en=0 and busy=0 while reset is high.
- Reset mid-frame aborts the frame. The partial word is discarded and out_valid is cleared.
- State machine: IDLE, DATA, [PARITY], STOP. All state transitions happen only on cycles with bit_stb=1.
- IDLE: if bit_stb and data_in=0 (start bit), go to DATA and set cnt=0. A high data_in stays in IDLE.
- DATA: on each bit_stb, shreg <= {shreg[WIDTH-2:0], data_in} and cnt <= cnt+1. When cnt==WIDTH-1, go to STOP (or PARITY if enabled).
- shift_en = bit_stb && state==DATA && !reset, exactly WIDTH pulses per frame.
- STOP on bit_stb, data_in=1, with no overrun condition: out_data <= final shreg and out_valid <= 1 at the next edge. Next state is IDLE.
  - Latency: out_valid rises 1 clk after the stop-bit strobe cycle.
- STOP on bit_stb, data_in=0: frame_err <= 1, word discarded, out_data/out_valid unchanged, next state IDLE.
- Output handshake:
  - out_valid clears on the edge where out_valid && out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- Overrun condition: a good stop bit while out_valid=1 and out_ready=0.
  - overrun <= 1 and the new word is dropped; the held word is kept.
- Simultaneous load and consume: a good stop bit on the same cycle as out_valid && out_ready.
  - The new word is loaded, out_valid stays 1, and this is not an overrun.
- Sticky flags: set has priority over clear_err in the same cycle.
- bit_stb may be continuous (one bit per clk) or sparse. Non-strobe cycles hold all state except the handshake and clear_err.
- Back-to-back frames: a start bit may be sampled on the first strobe after the stop strobe.

Optional Feature:
Macro SIPO_FRAME_CTRL_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled on one bit_stb, and an extra output parity_err (1 bit, sticky, reset 0, cleared by clear_err).
  - Even parity: if the XOR of the WIDTH data bits and the parity bit is 1, parity_err <= 1 at the stop strobe and the word is discarded.
  - A frame error takes precedence: on a bad stop bit only frame_err is set.
- Undefined: no PARITY state and no parity_err port. The frame is start + WIDTH data + stop.

Test Plan:
- Reset, then continuous bit_stb, serial 0,1,0,1,0,0,1,0,1,1 (start, 8'hA5 MSB-first, stop), out_ready=1 -> exactly 8 shift_en pulses; out_valid=1 for 1 clk one cycle after the stop strobe with out_data=8'hA5; busy low afterwards.
- bit_stb every 4th clk, frame carrying 8'h3C, out_ready=0 for 10 clks after valid -> out_data holds 8'h3C stable until ready; state advances only on strobes.
- Two frames, 8'h01 then 8'hFF, with out_ready=0 throughout -> out_data=8'h01, overrun=1, 8'hFF dropped. Pulse clear_err -> overrun=0, out_data still 8'h01.
- Frame 8'h55 with stop bit 0 -> frame_err=1, out_valid stays 0. clear_err and a new error in the same cycle -> frame_err stays 1.
- Assert reset after 4 data bits, then send a full frame 8'hC3 -> no output from the aborted frame; the next frame yields out_data=8'hC3.
- Parity feature on: frame 8'h07 with parity bit 1 -> valid, out_data=8'h07. Same frame with parity bit 0 -> parity_err=1, out_valid=0.
